// File: rtl/compute_ram_pkg.sv
// Shared definitions for the compute-RAM datapath: BRAM geometry, operand lane
// placement inside a BRAM word, and the operand loader state encoding.
package compute_ram_pkg;

    localparam int BRAM_DWIDTH    = 40;
    localparam int BRAM_AWIDTH    = 9;
    localparam int COMPUTE_DWIDTH = 8;

    // Operand lanes inside a BRAM word; the control stage unpacks from the same offsets.
    localparam int INPUT1_LSB = 0;
    localparam int INPUT2_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        FINISH
    } loader_state_t;

endpackage

// File: rtl/loader_watchdog.sv
// RUN-phase watchdog for operand_loader: counts RUN cycles and flags expiry
// during the last permitted cycle so the loader can abort on that edge.
module loader_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (run)
            count <= count + 1'b1;
    end

    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/operand_loader.sv
// Streams 8-bit operand pairs into consecutive BRAM words, then hands off to the
// control stage via start/done. Optional RUN watchdog: OPERAND_LOADER_TIMEOUT_EN.
module operand_loader #(
    parameter int BRAM_DWIDTH    = compute_ram_pkg::BRAM_DWIDTH,
    parameter int BRAM_AWIDTH    = compute_ram_pkg::BRAM_AWIDTH,
    parameter int COMPUTE_DWIDTH = compute_ram_pkg::COMPUTE_DWIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_req,
    input  logic [BRAM_AWIDTH-1:0]    base_addr,
    input  logic [BRAM_AWIDTH:0]      num_words,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [COMPUTE_DWIDTH-1:0] s_data1,
    input  logic [COMPUTE_DWIDTH-1:0] s_data2,
    output logic [BRAM_AWIDTH-1:0]    bram_addr,
    output logic [BRAM_DWIDTH-1:0]    bram_wdata,
    output logic                      bram_we,
    output logic                      start,
    input  logic                      done,
    output logic                      busy,
    output logic                      job_done,
    output logic                      timeout
);

    import compute_ram_pkg::*;

    loader_state_t          state;
    logic [BRAM_AWIDTH-1:0] base_q;
    logic [BRAM_AWIDTH:0]   count_q;
    logic [BRAM_AWIDTH:0]   idx_q;
    logic [BRAM_AWIDTH:0]   idx_inc;
    logic [BRAM_DWIDTH-1:0] packed_word;
    logic                   beat;
    logic                   last_beat;
    logic                   wd_expired;

    // s_ready depends on registered state only, never on s_valid.
    assign s_ready   = (state == LOAD);
    assign busy      = (state != IDLE);
    assign beat      = s_valid && s_ready;
    assign idx_inc   = idx_q + 1'b1;
    assign last_beat = beat && (idx_inc == count_q);

    // NOTE: default every always_comb output first so no path can infer a latch.
    always_comb begin
        packed_word = '0;
        packed_word[INPUT1_LSB +: COMPUTE_DWIDTH] = s_data1;
        packed_word[INPUT2_LSB +: COMPUTE_DWIDTH] = s_data2;
    end

`ifdef OPERAND_LOADER_TIMEOUT_EN
    loader_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (last_beat),
        .run     (state == RUN),
        .expired (wd_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign wd_expired         = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            start      <= 1'b0;
            job_done   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            bram_we  <= 1'b0;
            job_done <= 1'b0;
            timeout  <= 1'b0;

            case (state)
                IDLE: begin
                    if (load_req) begin
                        base_q  <= base_addr;
                        count_q <= num_words;
                        idx_q   <= '0;
                        if (num_words != '0) begin
                            state <= LOAD;
                        end else begin
                            state    <= FINISH;
                            job_done <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (beat) begin
                        bram_we    <= 1'b1;
                        bram_addr  <= base_q + idx_q[BRAM_AWIDTH-1:0];
                        bram_wdata <= packed_word;
                        idx_q      <= idx_inc;
                        if (last_beat)
                            state <= RUN;
                    end
                end

                // start lags RUN entry by one cycle so the last word is committed first.
                RUN: begin
                    if (done) begin
                        state    <= FINISH;
                        start    <= 1'b0;
                        job_done <= 1'b1;
                    end else if (wd_expired) begin
                        state    <= FINISH;
                        start    <= 1'b0;
                        job_done <= 1'b1;
                        timeout  <= 1'b1;
                    end else begin
                        start <= 1'b1;
                    end
                end

                FINISH: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed, table-driven bench for operand_loader; define OPERAND_LOADER_TIMEOUT_EN
// to also exercise the watchdog with a 16-cycle limit.
module tb_operand_loader;

`ifdef OPERAND_LOADER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic        clk;
    logic        reset;
    logic        load_req;
    logic [8:0]  base_addr;
    logic [9:0]  num_words;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data1;
    logic [7:0]  s_data2;
    logic [8:0]  bram_addr;
    logic [39:0] bram_wdata;
    logic        bram_we;
    logic        start;
    logic        done;
    logic        busy;
    logic        job_done;
    logic        timeout;

    operand_loader #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data1    (s_data1),
        .s_data2    (s_data2),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_we    (bram_we),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .job_done   (job_done),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with bram_we high is logged once, mid-cycle.
    logic [8:0]  wr_addr [$];
    logic [39:0] wr_data [$];
    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr.push_back(bram_addr);
            wr_data.push_back(bram_wdata);
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [8:0]      base;
        logic [9:0]      num;
        bit              toggle;
        logic [3:0][8:0] exp_addr;
    } job_vec_t;

    job_vec_t    jobs [3];
    logic [39:0] exp_data [4];

    task automatic issue(input logic [8:0] base, input logic [9:0] num);
        load_req  = 1'b1;
        base_addr = base;
        num_words = num;
        tick();
        load_req = 1'b0;
    endtask

    // Returns at #1 after the edge that accepted the final beat.
    task automatic feed(input int num, input bit toggle);
        int  beats = 0;
        int  cyc   = 0;
        bit  acc;
        while (beats < num && cyc < 200) begin
            s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_data1 = 8'(2 * beats + 1);
            s_data2 = 8'(2 * beats + 2);
            acc     = s_valid && s_ready;
            tick();
            if (acc) beats++;
            cyc++;
        end
        s_valid = 1'b0;
        check("beats_accepted", beats, num);
    endtask

    task automatic finish_job(input int wait_cycles);
        check("last_we_high", bram_we, 1'b1);
        check("start_not_with_last_we", start, 1'b0);
        tick();
        check("start_rise", start, 1'b1);
        check("we_low_after_load", bram_we, 1'b0);
        repeat (wait_cycles) tick();
        check("start_held", start, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("start_fall_on_done", start, 1'b0);
        check("job_done_pulse", job_done, 1'b1);
        tick();
        check("job_done_one_cycle", job_done, 1'b0);
        check("idle_after_finish", busy, 1'b0);
    endtask

    initial begin
        exp_data[0] = 40'h00_0000_0201;
        exp_data[1] = 40'h00_0000_0403;
        exp_data[2] = 40'h00_0000_0605;
        exp_data[3] = 40'h00_0000_0807;
        jobs[0] = '{base: 9'h000, num: 10'd4, toggle: 1'b0,
                    exp_addr: {9'h003, 9'h002, 9'h001, 9'h000}};
        jobs[1] = '{base: 9'h000, num: 10'd4, toggle: 1'b1,
                    exp_addr: {9'h003, 9'h002, 9'h001, 9'h000}};
        jobs[2] = '{base: 9'h1FE, num: 10'd4, toggle: 1'b0,
                    exp_addr: {9'h001, 9'h000, 9'h1FF, 9'h1FE}};

        reset     = 1'b1;
        load_req  = 1'b0;
        base_addr = '0;
        num_words = '0;
        s_valid   = 1'b0;
        s_data1   = '0;
        s_data2   = '0;
        done      = 1'b0;
        repeat (2) tick();

        check("rst_s_ready", s_ready, 1'b0);
        check("rst_bram_we", bram_we, 1'b0);
        check("rst_bram_addr", bram_addr, 9'h000);
        check("rst_bram_wdata", bram_wdata, 40'h0);
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_job_done", job_done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b0;
        tick();

        for (int j = 0; j < 3; j++) begin
            wr_addr.delete();
            wr_data.delete();
            issue(jobs[j].base, jobs[j].num);
            check("busy_after_req", busy, 1'b1);
            feed(int'(jobs[j].num), jobs[j].toggle);
            finish_job(20);
            check("write_count", wr_addr.size(), jobs[j].num);
            for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
                check($sformatf("job%0d_addr%0d", j, i), wr_addr[i], jobs[j].exp_addr[i]);
                check($sformatf("job%0d_data%0d", j, i), wr_data[i], exp_data[i]);
            end
        end

        // Asynchronous reset three beats into an eight-word job.
        issue(9'h020, 10'd8);
        feed(3, 1'b0);
        check("pre_reset_we", bram_we, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_we", bram_we, 1'b0);
        check("async_rst_addr", bram_addr, 9'h000);
        check("async_rst_wdata", bram_wdata, 40'h0);
        check("async_rst_s_ready", s_ready, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_start", start, 1'b0);
        #1 reset = 1'b0;
        tick();
        wr_addr.delete();
        wr_data.delete();
        issue(9'h010, 10'd2);
        feed(2, 1'b0);
        finish_job(3);
        check("post_rst_count", wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            check("post_rst_addr0", wr_addr[0], 9'h010);
            check("post_rst_addr1", wr_addr[1], 9'h011);
            check("post_rst_data1", wr_data[1], 40'h00_0000_0403);
        end

        // Stray done in IDLE, then an empty job.
        done = 1'b1;
        tick();
        done = 1'b0;
        check("stray_done_idle_busy", busy, 1'b0);
        check("stray_done_idle_jd", job_done, 1'b0);
        wr_addr.delete();
        issue(9'h055, 10'd0);
        check("zero_job_done", job_done, 1'b1);
        check("zero_busy_finish", busy, 1'b1);
        check("zero_no_start", start, 1'b0);
        tick();
        check("zero_jd_one_cycle", job_done, 1'b0);
        check("zero_idle", busy, 1'b0);
        check("zero_no_writes", wr_addr.size(), 0);

        // Stray done in LOAD and load_req in RUN must both be ignored.
        wr_addr.delete();
        issue(9'h100, 10'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("stray_done_load", s_ready, 1'b1);
        feed(2, 1'b0);
        tick();
        check("run_start", start, 1'b1);
        load_req  = 1'b1;
        base_addr = 9'h0AA;
        num_words = 10'd3;
        tick();
        load_req = 1'b0;
        check("req_in_run_s_ready", s_ready, 1'b0);
        check("req_in_run_start", start, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("req_in_run_jd", job_done, 1'b1);
        repeat (3) tick();
        check("req_not_queued", busy, 1'b0);
        check("req_in_run_writes", wr_addr.size(), 2);
        if (wr_addr.size() >= 2)
            check("req_in_run_addr1", wr_addr[1], 9'h101);

`ifdef OPERAND_LOADER_TIMEOUT_EN
        begin
            int cnt = 0;
            issue(9'h030, 10'd1);
            feed(1, 1'b0);
            while (!timeout && cnt < 40) begin
                tick();
                cnt++;
            end
            check("timeout_cycles", cnt, 16);
            check("timeout_job_done", job_done, 1'b1);
            check("timeout_start_low", start, 1'b0);
            tick();
            check("timeout_one_cycle", timeout, 1'b0);
            check("timeout_idle", busy, 1'b0);
        end
`else
        check("timeout_tied_low", timeout, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the compute-RAM control stage. Accepts a valid/ready stream of 8-bit operand pairs, packs each pair into one 40-bit BRAM word at consecutive addresses from a programmable base, then asserts `start` to the control stage and holds it until that stage pulses `done`. Sits between the host/DMA operand stream and the BRAM input region read by the control logic.

## Interface
- `BRAM_DWIDTH`, 40, BRAM word width
- `BRAM_AWIDTH`, 9, BRAM address width
- `COMPUTE_DWIDTH`, 8, operand width
- `TIMEOUT_CYCLES`, 1024, watchdog limit; used only with `OPERAND_LOADER_TIMEOUT_EN`
- `clk` in 1: the single clock
- `reset` in 1: asynchronous, active-high reset
- `load_req` in 1: begin a job; sampled in IDLE only
- `base_addr` in BRAM_AWIDTH: first write address
- `num_words` in BRAM_AWIDTH+1: operand pairs to load, 0..512
- `s_valid` in 1: operand pair valid
- `s_ready` out 1: loader accepts pair
- `s_data1` in COMPUTE_DWIDTH: operand 1
- `s_data2` in COMPUTE_DWIDTH: operand 2
- `bram_addr` out BRAM_AWIDTH: write address
- `bram_wdata` out BRAM_DWIDTH: `{24'b0, s_data2, s_data1}`
- `bram_we` out 1: write strobe
- `start` out 1: level to control stage; high while compute runs
- `done` in 1: one-cycle completion pulse from control stage
- `busy` out 1: high in any state other than IDLE
- `job_done` out 1: one-cycle pulse at job end
- `timeout` out 1: one-cycle pulse on watchdog abort; constant 0 without the macro

## Operation
- States: IDLE, LOAD, RUN, FINISH
- IDLE: `s_ready`=0. On `load_req`=1, latch `base_addr` and `num_words`, clear index. If `num_words`≠0 go to LOAD, otherwise go to FINISH (no writes, no `start`).
- LOAD: `s_ready`=1. Each `s_valid&&s_ready` beat registers `bram_we`=1, `bram_addr`=base+idx, `bram_wdata` packed, and increments idx. The beat where idx+1==count goes to RUN.
- RUN: `start`=1. On `done`=1 go to FINISH.
- FINISH: `job_done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is BRAM_AWIDTH bits and wraps modulo 2^BRAM_AWIDTH. Example: base 0x1FE with 4 words writes 0x1FE, 0x1FF, 0x000, 0x001.
- `load_req` outside IDLE is ignored. `done` outside RUN is ignored.
- Asserting `reset` mid-job aborts immediately. Partially written BRAM contents are left as-is.

## Timing
- Reset values: `s_ready`=0, `bram_we`=0, `bram_addr`=0, `bram_wdata`=0, `start`=0, `busy`=0, `job_done`=0, `timeout`=0, state IDLE.
- `s_ready` is decoded from registered state only. It has no combinational path from `s_valid`.
- Write latency is 1: a beat accepted at edge k gives `bram_we`=1 during cycle k..k+1. `bram_we` is 0 in any cycle with no accepted beat.
- `start` is registered `(state==RUN)`. It rises one cycle after the last `bram_we` cycle, so the final word is committed before the control stage starts.
- `done` sampled at edge d: state goes to FINISH at d, `start`=0 and `job_done`=1 during d..d+1, and the block is in IDLE at d+1.
- A new `load_req` is accepted at the earliest one cycle after `job_done`.
- `busy` is high from the cycle after `load_req` acceptance through the FINISH cycle.

## Configuration
- Macro: `OPERAND_LOADER_TIMEOUT_EN`.
- Defined: a counter clears on RUN entry and increments each RUN cycle. On reaching `TIMEOUT_CYCLES` without `done`, the block goes to FINISH and pulses both `timeout` and `job_done` in the same cycle.
- Undefined: no counter; RUN waits for `done` indefinitely; `timeout` is tied to 0.

## Structure
- Shared package `compute_ram_pkg` holds:
  - BRAM_DWIDTH, BRAM_AWIDTH, COMPUTE_DWIDTH
  - the operand bit-lane positions in the BRAM word (input1 [7:0], input2 [15:8]), shared with the control stage
  - the loader state enum
- One sub-module, `loader_watchdog`: counter plus compare, instantiated only under the macro.

## Test plan
- Reset during LOAD after 3 of 8 beats: all outputs return to reset values asynchronously. A new job with base 0x010 and 2 words then writes 0x010 and 0x011.
- base 0x000, 4 words, `s_valid` held high: writes on 4 consecutive cycles with `bram_wdata` = 0x00_0000_0201, 0x0403, … for pairs (1,2),(3,4),…. `start` rises 1 cycle after the last write. A `done` pulse 20 cycles later gives `job_done` 1 cycle later and `start`=0.
- Same job with `s_valid` toggling every cycle: exactly 4 writes, addresses contiguous, no write on idle cycles.
- base 0x1FE, 4 words: addresses 0x1FE, 0x1FF, 0x000, 0x001 (wrap).
- `num_words`=0: no `bram_we`, no `start`, `job_done` pulse 1 cycle after `load_req`. A `load_req` pulse while in RUN and stray `done` pulses in IDLE/LOAD have no effect.
- With `OPERAND_LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `done` never asserted: `timeout` and `job_done` pulse together after 16 RUN cycles, then IDLE.
